// File: rtl/ahb_pixfifo_slave.sv
// ahb_pixfifo_slave
//   AHB-Lite responder that packs an 8-bit pixel stream into 32-bit words,
//   buffers them in a FIFO and exposes them through four word registers:
//   CTRL (0x0), STATUS (0x4), DATA (0x8, read pops) and TIMEOUT (0xC).
//   Writes complete with no wait states. Reads take one wait state.
//   A DATA read on an empty FIFO stalls until data arrives, or until the
//   stall count reaches TIMEOUT, and then ends with an ERROR response.
//
// Ports
//   SYSCLK, NSYSRESET          clock, synchronous active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/  AHB-Lite address and data phase inputs
//   HSIZE/HWDATA/HREADYIN
//   HRDATA/HREADYOUT/HRESP     AHB-Lite responses
//   PIX_VALID/PIX_DATA/        pixel stream; PIX_FSTART restarts word packing
//   PIX_FSTART
//   IRQ                        level interrupt (only with AHB_PIXFIFO_IRQ_EN)
//
// Optional feature macro: AHB_PIXFIFO_IRQ_EN adds the registered IRQ output.
//
// state   | meaning
// IDLE    | ready; accepts address phases
// RD_WAIT | read data phase; waits for FIFO data on DATA reads
// ERR1    | first ERROR cycle (HREADYOUT=0)
// ERR2    | second ERROR cycle (HREADYOUT=1)

module ahb_pixfifo_slave #(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter logic [7:0]  TIMEOUT_RST = 8'd16
) (
  input  logic        SYSCLK,
  input  logic        NSYSRESET,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        PIX_VALID,
  input  logic [7:0]  PIX_DATA,
  input  logic        PIX_FSTART
`ifdef AHB_PIXFIFO_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_DATA = 2'd2, A_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ERR1, S_ERR2} state_e;

  state_e                state_q, state_d;
  logic [7:0]            stall_q, stall_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [1:0]            addr_q, addr_d;
  logic                  enable_q, enable_d;
  logic [7:0]            thr_q, thr_d;
  logic [7:0]            timeout_q, timeout_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH_LOG2:0]   lvl_q, lvl_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [23:0]           pack_q, pack_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           mem_q [DEPTH];

  logic        acc, legal, pop, push, push_ok, ovf_set, ovf_clr, flush, empty, full;
  logic [31:0] reg_rdata, status_w;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:24], HWDATA[15:8]};

  assign acc   = (state_q == S_IDLE) && HSEL && HREADYIN && HTRANS[1];
  assign legal = (HSIZE == 3'b010);
  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == LVL_FULL);
  assign HRDATA = hrdata_q;

  // Write data phase commits to the address latched in the previous cycle.
  always_comb begin
    enable_d  = enable_q;
    thr_d     = thr_q;
    timeout_d = timeout_q;
    ovf_clr   = 1'b0;
    flush     = 1'b0;
    if (wr_pend_q) begin
      case (addr_q)
        A_CTRL:    begin enable_d = HWDATA[0]; thr_d = HWDATA[23:16]; flush = HWDATA[1]; end
        A_STATUS:  ovf_clr = HWDATA[18];
        A_TIMEOUT: timeout_d = HWDATA[7:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    status_w = '0;
    status_w[DEPTH_LOG2:0] = lvl_q;
    status_w[16] = empty;
    status_w[17] = full;
    status_w[18] = overflow_q;
    case (addr_q)
      A_CTRL:    reg_rdata = {8'h00, thr_q, 15'h0000, enable_q};
      A_STATUS:  reg_rdata = status_w;
      A_TIMEOUT: reg_rdata = {24'h000000, timeout_q};
      default:   reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    hrdata_d  = hrdata_q;
    pop       = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    wr_pend_d = acc && legal && HWRITE;
    addr_d    = (acc && legal) ? HADDR[3:2] : addr_q;
    case (state_q)
      S_IDLE: begin
        if (acc && !legal) begin
          state_d = S_ERR1;
        end else if (acc && !HWRITE) begin
          state_d = S_RD_WAIT;
          stall_d = '0;
        end
      end
      S_RD_WAIT: begin
        HREADYOUT = 1'b0;
        if (addr_q != A_DATA) begin
          hrdata_d = reg_rdata;
          state_d  = S_IDLE;
        end else if (!empty) begin
          hrdata_d = mem_q[rd_ptr_q];
          pop      = 1'b1;
          state_d  = S_IDLE;
        end else if (stall_q == timeout_q) begin
          state_d = S_ERR1;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      default: begin
        HRESP   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Packer and FIFO bookkeeping. FLUSH wins over any push in the same cycle.
  always_comb begin
    pack_d   = pack_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    lvl_d    = lvl_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enable_q && PIX_VALID) begin
      if (PIX_FSTART) begin
        pack_d[7:0] = PIX_DATA;
        cnt_d       = 2'd1;
      end else begin
        case (cnt_q)
          2'd0:    pack_d[7:0]   = PIX_DATA;
          2'd1:    pack_d[15:8]  = PIX_DATA;
          2'd2:    pack_d[23:16] = PIX_DATA;
          default: push = 1'b1;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
    end
    push_ok = push && !flush && (!full || pop);
    ovf_set = push && !flush && full && !pop;
    if (flush) begin
      cnt_d    = '0;
      lvl_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   lvl_d = lvl_q + LVL_ONE;
        2'b01:   lvl_d = lvl_q - LVL_ONE;
        default: ;
      endcase
    end
    overflow_d = (overflow_q && !ovf_clr) || ovf_set;
  end

  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      state_q    <= S_IDLE;
      stall_q    <= '0;
      hrdata_q   <= '0;
      wr_pend_q  <= 1'b0;
      addr_q     <= '0;
      enable_q   <= 1'b0;
      thr_q      <= '0;
      timeout_q  <= TIMEOUT_RST;
      overflow_q <= 1'b0;
      lvl_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pack_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      hrdata_q   <= hrdata_d;
      wr_pend_q  <= wr_pend_d;
      addr_q     <= addr_d;
      enable_q   <= enable_d;
      thr_q      <= thr_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      lvl_q      <= lvl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {PIX_DATA, pack_q};
  end

`ifdef AHB_PIXFIFO_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = (enable_q && (16'(lvl_q) >= 16'(thr_q)) && (thr_q != 8'd0)) || overflow_q;
  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) irq_q <= 1'b0;
    else            irq_q <= irq_d;
  end
  assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_ahb_pixfifo_slave.sv
// Bench for ahb_pixfifo_slave: directed cases plus a randomized operation
// mix checked against a queue-based model of the FIFO, packer and registers.
module tb_ahb_pixfifo_slave;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic        sysclk = 1'b0;
  logic        nsysreset;
  logic        hsel, hwrite, hreadyin, pix_valid, pix_fstart;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata;
  logic        hreadyout, hresp;
  logic [7:0]  pix_data;
`ifdef AHB_PIXFIFO_IRQ_EN
  logic        irq;
`endif

  ahb_pixfifo_slave #(.DEPTH_LOG2(DL2), .TIMEOUT_RST(8'd16)) dut (
    .SYSCLK(sysclk), .NSYSRESET(nsysreset), .HSEL(hsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADYIN(hreadyin), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .PIX_VALID(pix_valid), .PIX_DATA(pix_data), .PIX_FSTART(pix_fstart)
`ifdef AHB_PIXFIFO_IRQ_EN
    , .IRQ(irq)
`endif
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_fifo[$];
  logic [7:0]  m_part[$];
  bit          m_en, m_ovf;
  logic [7:0]  m_thr, m_to;

  task automatic model_reset();
    m_fifo.delete(); m_part.delete();
    m_en = 0; m_ovf = 0; m_thr = 8'd0; m_to = 8'd16;
  endtask

  task automatic model_pix(input logic [7:0] b, input bit fs);
    if (m_en) begin
      if (fs) m_part.delete();
      m_part.push_back(b);
      if (!fs && m_part.size() == 4) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
        else m_ovf = 1;
        m_part.delete();
      end
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_fifo.size());
    s[16] = (m_fifo.size() == 0);
    s[17] = (m_fifo.size() == DEPTH);
    s[18] = m_ovf;
    return s;
  endfunction

  // ---------------- bus / pixel drivers ----------------
  logic [31:0] rd_data;
  int          rd_waits, rd_errlow;
  logic        rd_err;

  task automatic addr_phase(input logic [3:0] a, input logic w, input logic [2:0] sz);
    hsel = 1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
  endtask

  task automatic bus_idle();
    hsel = 0; htrans = 2'b00; hwrite = 0;
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1, 3'b010);
    @(posedge sysclk); #1;
    bus_idle();
    hwdata = d;
    check_eq("wr_ready", hreadyout, 1);
    check_eq("wr_resp", hresp, 0);
    @(posedge sysclk); #1;
  endtask

  task automatic ahb_read(input logic [3:0] a);
    bit done;
    done = 0;
    addr_phase(a, 1'b0, 3'b010);
    @(posedge sysclk); #1;
    bus_idle();
    rd_waits = 0; rd_errlow = 0; rd_err = 0; rd_data = '0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (hreadyout) begin
        done = 1; rd_data = hrdata; rd_err = hresp;
      end else begin
        rd_waits++;
        if (hresp) rd_errlow++;
        @(posedge sysclk); #1;
      end
    end
    check_eq("rd_done", 32'(done), 1);
    if (rd_err) begin @(posedge sysclk); #1; end
  endtask

  task automatic expect_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    ahb_read(a);
    check_eq({tag, "_data"}, rd_data, exp);
    check_eq({tag, "_waits"}, rd_waits, 1);
    check_eq({tag, "_resp"}, rd_err, 0);
  endtask

  task automatic data_read_model(input string tag);
    logic [31:0] prev;
    if (m_fifo.size() == 0) begin
      prev = hrdata;
      ahb_read(4'h8);
      check_eq({tag, "_err_waits"}, rd_waits, 32'(m_to) + 2);
      check_eq({tag, "_err_resp"}, rd_err, 1);
      check_eq({tag, "_err1"}, rd_errlow, 1);
      check_eq({tag, "_err_hold"}, rd_data, prev);
    end else begin
      expect_rd(tag, 4'h8, m_fifo.pop_front());
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    ahb_write(a, d);
    case (a[3:2])
      2'd0: begin
        m_en = d[0]; m_thr = d[23:16];
        if (d[1]) begin m_fifo.delete(); m_part.delete(); end
      end
      2'd1: if (d[18]) m_ovf = 0;
      2'd3: m_to = d[7:0];
      default: ;
    endcase
  endtask

  task automatic ahb_bad(input logic [3:0] a, input logic w);
    addr_phase(a, w, 3'b000);
    @(posedge sysclk); #1;
    bus_idle();
    hwdata = 32'hFFFF_FFFF;
    check_eq("bad_err1_ready", hreadyout, 0);
    check_eq("bad_err1_resp", hresp, 1);
    @(posedge sysclk); #1;
    check_eq("bad_err2_ready", hreadyout, 1);
    check_eq("bad_err2_resp", hresp, 1);
    @(posedge sysclk); #1;
  endtask

  task automatic pix(input logic [7:0] b, input bit fs);
    pix_valid = 1; pix_data = b; pix_fstart = fs;
    @(posedge sysclk); #1;
    pix_valid = 0; pix_fstart = 0;
    model_pix(b, fs);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    logic [31:0] d;
    nsysreset = 0; hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 3'b010;
    hwdata = 0; hreadyin = 1; pix_valid = 0; pix_data = 0; pix_fstart = 0;
    model_reset();
    repeat (3) @(posedge sysclk);
    #1;
    check_eq("rst_hrdata", hrdata, 0);
    check_eq("rst_ready", hreadyout, 1);
    check_eq("rst_resp", hresp, 0);
    nsysreset = 1;
    @(posedge sysclk); #1;

    expect_rd("rst_status", 4'h4, 32'h0001_0000);
    expect_rd("rst_timeout", 4'hC, 32'd16);
    expect_rd("rst_ctrl", 4'h0, 32'd0);

    reg_write(4'h0, 32'h1);
    expect_rd("ctrl_en", 4'h0, 32'h1);

    pix(8'h11, 0); pix(8'h22, 0); pix(8'h33, 0); pix(8'h44, 0);
    expect_rd("st_one", 4'h4, 32'h1);
    data_read_model("data1");
    check_eq("data1_const", rd_data, 32'h4433_2211);
    expect_rd("st_empty", 4'h4, 32'h0001_0000);

    reg_write(4'hC, 32'd4);
    data_read_model("to4");
    check_eq("to4_waits_const", rd_waits, 6);
    expect_rd("to4_nopop", 4'h4, 32'h0001_0000);
    reg_write(4'hC, 32'd0);
    data_read_model("to0");

    // write TIMEOUT immediately followed by a read of TIMEOUT
    addr_phase(4'hC, 1'b1, 3'b010);
    @(posedge sysclk); #1;
    hwdata = 32'd7;
    addr_phase(4'hC, 1'b0, 3'b010);
    check_eq("b2b_wr_ready", hreadyout, 1);
    @(posedge sysclk); #1;
    bus_idle();
    check_eq("b2b_rd_wait", hreadyout, 0);
    @(posedge sysclk); #1;
    check_eq("b2b_rd_ready", hreadyout, 1);
    check_eq("b2b_rd_data", hrdata, 32'd7);
    m_to = 8'd7;

    for (int i = 0; i < 20; i++) pix(8'(i * 7 + 1), 0);
    expect_rd("full", 4'h4, 32'h0006_0004);
    reg_write(4'h4, 32'h0004_0000);
    expect_rd("ovf_clr", 4'h4, 32'h0002_0004);
    data_read_model("drain0");
    check_eq("drain0_const", rd_data, 32'h160F_0801);
    for (int i = 1; i < 4; i++) data_read_model("drain");

    pix(8'h55, 0); pix(8'h66, 0); pix(8'hAA, 1); pix(8'hBB, 0); pix(8'hCC, 0); pix(8'hDD, 0);
    expect_rd("fstart_st", 4'h4, 32'h1);
    data_read_model("fstart");
    check_eq("fstart_const", rd_data, 32'hDDCC_BBAA);

    ahb_bad(4'h0, 1'b1);
    expect_rd("ctrl_after_bad", 4'h0, 32'h1);
    ahb_bad(4'h4, 1'b0);

    hreadyin = 0;
    addr_phase(4'h8, 1'b0, 3'b010);
    @(posedge sysclk); #1;
    bus_idle();
    hreadyin = 1;
    check_eq("hreadyin_gate", hreadyout, 1);

    reg_write(4'h8, 32'hDEAD_BEEF);
    expect_rd("data_wr_ignored", 4'h4, 32'h0001_0000);

    // stalled DATA read released by arriving pixels
    reg_write(4'hC, 32'd20);
    fork
      ahb_read(4'h8);
      begin
        repeat (3) @(posedge sysclk);
        #1;
        pix(8'h01, 0); pix(8'h02, 0); pix(8'h03, 0); pix(8'h04, 0);
      end
    join
    check_eq("stall_data", rd_data, 32'h0403_0201);
    check_eq("stall_resp", rd_err, 0);
    check_eq("stall_waits", rd_waits, 7);
    check_eq("stall_model", rd_data, m_fifo.pop_front());

    pix(8'h91, 0); pix(8'h92, 0); pix(8'h93, 0); pix(8'h94, 0); pix(8'h95, 0); pix(8'h96, 0);
    reg_write(4'h0, 32'h3);
    expect_rd("flush_st", 4'h4, 32'h0001_0000);
    expect_rd("ctrl_flush_rd0", 4'h0, 32'h1);
    pix(8'h10, 0); pix(8'h20, 0); pix(8'h30, 0); pix(8'h40, 0);
    data_read_model("after_flush");
    check_eq("after_flush_const", rd_data, 32'h4030_2010);
    for (int i = 0; i < 20; i++) pix(8'(i), 0);
    reg_write(4'h0, 32'h3);
    expect_rd("flush_keep_ovf", 4'h4, 32'h0005_0000);
    reg_write(4'h4, 32'h0004_0000);

`ifdef AHB_PIXFIFO_IRQ_EN
    reg_write(4'h0, 32'h0002_0001);
    pix(8'h01, 0); pix(8'h02, 0); pix(8'h03, 0); pix(8'h04, 0);
    check_eq("irq_lvl1", irq, 0);
    pix(8'h05, 0); pix(8'h06, 0); pix(8'h07, 0); pix(8'h08, 0);
    check_eq("irq_lag", irq, 0);
    @(posedge sysclk); #1;
    check_eq("irq_rise", irq, 1);
    data_read_model("irq_pop");
    check_eq("irq_hold", irq, 1);
    @(posedge sysclk); #1;
    check_eq("irq_fall", irq, 0);
    data_read_model("irq_drain");
`endif

    reg_write(4'h0, 32'h00AB_0001);
    expect_rd("ctrl_thr", 4'h0, 32'h00AB_0001);

    // reset in the middle of a stalled read
    addr_phase(4'h8, 1'b0, 3'b010);
    @(posedge sysclk); #1;
    bus_idle();
    check_eq("midrst_stall", hreadyout, 0);
    @(posedge sysclk); #1;
    nsysreset = 0;
    @(posedge sysclk); #1;
    check_eq("midrst_ready", hreadyout, 1);
    check_eq("midrst_resp", hresp, 0);
    check_eq("midrst_hrdata", hrdata, 0);
    nsysreset = 1;
    model_reset();
    @(posedge sysclk); #1;
    expect_rd("midrst_timeout", 4'hC, 32'd16);
    expect_rd("midrst_ctrl", 4'h0, 32'd0);

    // randomized operation mix against the model
    reg_write(4'h0, 32'h1);
    reg_write(4'hC, 32'd3);
    for (int it = 0; it < 250; it++) begin
      @(posedge sysclk); #1;
`ifdef AHB_PIXFIFO_IRQ_EN
      check_eq("r_irq", irq, ((m_en && m_fifo.size() >= m_thr && m_thr != 0) || m_ovf) ? 1 : 0);
`endif
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: begin
          int n;
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) pix(8'($urandom), $urandom_range(0, 7) == 0);
        end
        4, 5: data_read_model("r_data");
        6:    expect_rd("r_status", 4'h4, m_status());
        7: begin
          d = {8'h00, 8'($urandom_range(0, 4)), 14'h0000,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0)};
          reg_write(4'h0, d);
          expect_rd("r_ctrl", 4'h0, {8'h00, m_thr, 15'h0000, m_en});
        end
        8: reg_write(4'h4, ($urandom_range(0, 1) == 1) ? 32'h0004_0000 : 32'h0000_0000);
        default: begin
          reg_write(4'hC, 32'($urandom_range(0, 5)));
          expect_rd("r_timeout", 4'hC, 32'(m_to));
        end
      endcase
    end
    expect_rd("r_final_status", 4'h4, m_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
